// File: rtl/sync_handshake_rx_pkg.sv
// Shared constants and state encoding for the destination-side toggle-handshake CDC receiver.
package sync_handshake_rx_pkg;

   localparam int SYNC_STAGES_MIN = 2;
   localparam int SYNC_STAGES_MAX = 4;

   // Scheduler payload: target address bits (less 3), page offset, op type, padded to a word
   localparam int ADDR_WIDTH         = 27;
   localparam int PAGE_OFFSET_WIDTH  = 3;
   localparam int OP_TYPE_WIDTH      = 3;
   localparam int PAYLOAD_PAD        = 2;
   localparam int DEFAULT_DATA_WIDTH = (ADDR_WIDTH - 3) + PAGE_OFFSET_WIDTH + OP_TYPE_WIDTH + PAYLOAD_PAD;

   typedef enum logic {
      RX_IDLE = 1'b0,
      RX_HOLD = 1'b1
   } rx_state_e;

endpackage

// File: rtl/sync_handshake_rx_if.sv
// Toggle req/ack bus plus consumer valid/ready side of the CDC receiver.
interface sync_handshake_rx_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  req_tgl_a;
   logic [DATA_WIDTH-1:0] data_a;
   logic                  ack_tgl;
   logic [DATA_WIDTH-1:0] data_o;
   logic                  valid_o;
   logic                  ready_i;

   modport master (
      output req_tgl_a,
      output data_a,
      input  ack_tgl,
      input  data_o,
      input  valid_o,
      output ready_i
   );

   modport slave (
      input  req_tgl_a,
      input  data_a,
      output ack_tgl,
      output data_o,
      output valid_o,
      input  ready_i
   );
endinterface

// File: rtl/sync_handshake_rx_sync_bit_chain.sv
// Plain flop chain for synchronizing asynchronous bits; no logic between stages.
module sync_bit_chain #(
   parameter int STAGES = 2,
   parameter int WIDTH  = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] chain [STAGES];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < STAGES; i++) chain[i] <= '0;
      end else begin
         chain[0] <= d;
         for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/sync_handshake_rx.sv
// Destination-side toggle-handshake receiver with level synchronizers and edge pulses.
// state   | meaning
// RX_IDLE | no payload held; waiting for a req toggle edge
// RX_HOLD | payload captured and presented on data_o/valid_o until accepted
module sync_handshake_rx
   import sync_handshake_rx_pkg::*;
#(
   parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
   parameter int SYNC_STAGES = 2,
   parameter int NUM_LVL     = 2
) (
   input  logic               clk_83M,
   input  logic               rst_n,
   sync_handshake_rx_if.slave hs,
   output logic               err_o,
   input  logic [NUM_LVL-1:0] lvl_a,
   output logic [NUM_LVL-1:0] lvl_o,
   output logic [NUM_LVL-1:0] lvl_rise_o,
   output logic [NUM_LVL-1:0] lvl_fall_o
);

   if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
      $error("sync_handshake_rx: SYNC_STAGES out of range");
   end

   logic                  req_s;
   logic                  req_d;
   logic                  req_edge;
   rx_state_e             state_q;
   rx_state_e             state_d;
   logic                  capture;
   logic                  accept;
   logic                  err_set;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  ack_q;
   logic                  err_q;
   logic [NUM_LVL-1:0]    lvl_s;
   logic [NUM_LVL-1:0]    lvl_prev;

   sync_bit_chain #(
      .STAGES (SYNC_STAGES),
      .WIDTH  (1)
   ) u_req_sync (
      .clk   (clk_83M),
      .rst_n (rst_n),
      .d     (hs.req_tgl_a),
      .q     (req_s)
   );

   sync_bit_chain #(
      .STAGES (SYNC_STAGES),
      .WIDTH  (NUM_LVL)
   ) u_lvl_sync (
      .clk   (clk_83M),
      .rst_n (rst_n),
      .d     (lvl_a),
      .q     (lvl_s)
   );

   assign req_edge = req_s ^ req_d;

   always_ff @(posedge clk_83M) begin
      if (!rst_n) begin
         state_q <= RX_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // An edge seen while holding is a violation; it is consumed without capture or extra ack.
   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      accept  = 1'b0;
      err_set = 1'b0;
      unique case (state_q)
         RX_IDLE: begin
            if (req_edge) begin
               capture = 1'b1;
               state_d = RX_HOLD;
            end
         end
         RX_HOLD: begin
            err_set = req_edge;
            if (hs.ready_i) begin
               accept  = 1'b1;
               state_d = RX_IDLE;
            end
         end
         default: state_d = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk_83M) begin
      if (!rst_n) begin
         req_d    <= 1'b0;
         data_q   <= '0;
         ack_q    <= 1'b0;
         err_q    <= 1'b0;
         lvl_prev <= '0;
      end else begin
         req_d    <= req_s;
         lvl_prev <= lvl_s;
         if (capture) data_q <= hs.data_a;
         if (accept)  ack_q  <= ~ack_q;
         if (err_set) err_q  <= 1'b1;
      end
   end

   assign hs.data_o  = data_q;
   assign hs.valid_o = (state_q == RX_HOLD);
   assign hs.ack_tgl = ack_q;
   assign err_o      = err_q;

   assign lvl_o      = lvl_s;
   assign lvl_rise_o = lvl_s & ~lvl_prev;
   assign lvl_fall_o = ~lvl_s & lvl_prev;

endmodule

// File: tb/tb_sync_handshake_rx.sv
// Directed bench for sync_handshake_rx at SYNC_STAGES=2 with a SYNC_STAGES=3 copy for latency.
module tb_sync_handshake_rx;

   logic       clk_83M = 1'b0;
   logic       rst_n;
   logic [1:0] lvl_a;
   logic [1:0] lvl_o, lvl_rise_o, lvl_fall_o;
   logic [1:0] lvl3_o, lvl3_rise_o, lvl3_fall_o;
   logic       err_o, err3_o;

   int vec_cnt  = 0;
   int err_cnt  = 0;
   logic       ack_prev;

   always #5 clk_83M = ~clk_83M;

   sync_handshake_rx_if #(.DATA_WIDTH(32)) hs  ();
   sync_handshake_rx_if #(.DATA_WIDTH(32)) hs3 ();

   assign hs3.req_tgl_a = hs.req_tgl_a;
   assign hs3.data_a    = hs.data_a;
   assign hs3.ready_i   = hs.ready_i;

   sync_handshake_rx #(.DATA_WIDTH(32), .SYNC_STAGES(2), .NUM_LVL(2)) dut (
      .clk_83M    (clk_83M),
      .rst_n      (rst_n),
      .hs         (hs.slave),
      .err_o      (err_o),
      .lvl_a      (lvl_a),
      .lvl_o      (lvl_o),
      .lvl_rise_o (lvl_rise_o),
      .lvl_fall_o (lvl_fall_o)
   );

   sync_handshake_rx #(.DATA_WIDTH(32), .SYNC_STAGES(3), .NUM_LVL(2)) dut3 (
      .clk_83M    (clk_83M),
      .rst_n      (rst_n),
      .hs         (hs3.slave),
      .err_o      (err3_o),
      .lvl_a      (lvl_a),
      .lvl_o      (lvl3_o),
      .lvl_rise_o (lvl3_rise_o),
      .lvl_fall_o (lvl3_fall_o)
   );

   task automatic tick();
      @(posedge clk_83M);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      assert (obs === exp) else begin
         err_cnt++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_valid(input string tag, input int budget);
      for (int k = 0; k < budget; k++) begin
         if (hs.valid_o === 1'b1) break;
         tick();
      end
      chk(tag, {31'd0, hs.valid_o}, 32'd1);
   endtask

   initial begin
      rst_n        = 1'b0;
      hs.req_tgl_a = 1'b0;
      hs.data_a    = '0;
      hs.ready_i   = 1'b0;
      lvl_a        = 2'b00;
      tick();
      tick();
      chk("rst_valid", {31'd0, hs.valid_o}, 32'd0);
      chk("rst_ack",   {31'd0, hs.ack_tgl}, 32'd0);
      chk("rst_err",   {31'd0, err_o},      32'd0);
      chk("rst_data",  hs.data_o,           32'd0);
      chk("rst_lvl",   {30'd0, lvl_o},      32'd0);
      rst_n = 1'b1;
      tick();

      // single transfer, latency SYNC_STAGES+1
      hs.data_a    = 32'hA5A5_0123;
      hs.req_tgl_a = 1'b1;
      hs.ready_i   = 1'b1;
      tick();
      chk("t1_e1_valid", {31'd0, hs.valid_o}, 32'd0);
      tick();
      chk("t1_e2_valid", {31'd0, hs.valid_o}, 32'd0);
      tick();
      chk("t1_e3_valid", {31'd0, hs.valid_o}, 32'd1);
      chk("t1_e3_data",  hs.data_o,           32'hA5A5_0123);
      chk("t1_e3_ack",   {31'd0, hs.ack_tgl}, 32'd0);
      chk("s3_e3_valid", {31'd0, hs3.valid_o}, 32'd0);
      tick();
      chk("t1_e4_valid", {31'd0, hs.valid_o}, 32'd0);
      chk("t1_e4_ack",   {31'd0, hs.ack_tgl}, 32'd1);
      chk("s3_e4_valid", {31'd0, hs3.valid_o}, 32'd1);
      chk("s3_e4_data",  hs3.data_o,          32'hA5A5_0123);
      tick();
      chk("s3_e5_valid", {31'd0, hs3.valid_o}, 32'd0);
      chk("s3_e5_ack",   {31'd0, hs3.ack_tgl}, 32'd1);
      chk("t1_e5_ack",   {31'd0, hs.ack_tgl},  32'd1);

      // backpressure
      hs.ready_i   = 1'b0;
      hs.data_a    = 32'h1234_5678;
      hs.req_tgl_a = 1'b0;
      wait_valid("bp_wait", 10);
      for (int c = 0; c < 10; c++) begin
         tick();
         chk("bp_valid", {31'd0, hs.valid_o}, 32'd1);
         chk("bp_data",  hs.data_o,           32'h1234_5678);
         chk("bp_ack",   {31'd0, hs.ack_tgl}, 32'd1);
      end
      hs.ready_i = 1'b1;
      tick();
      chk("bp_acc_valid", {31'd0, hs.valid_o}, 32'd0);
      chk("bp_acc_ack",   {31'd0, hs.ack_tgl}, 32'd0);
      chk("bp3_acc_ack",  {31'd0, hs3.ack_tgl}, 32'd0);
      tick();
      tick();
      chk("bp_once_ack",  {31'd0, hs.ack_tgl}, 32'd0);
      chk("bp_once_valid",{31'd0, hs.valid_o}, 32'd0);

      // back-to-back, ready held high
      for (int i = 1; i <= 4; i++) begin
         ack_prev     = hs.ack_tgl;
         hs.data_a    = i;
         hs.req_tgl_a = ~hs.req_tgl_a;
         wait_valid("b2b_wait", 10);
         chk("b2b_data", hs.data_o, i);
         tick();
         chk("b2b_ack", {31'd0, hs.ack_tgl}, {31'd0, ~ack_prev});
      end
      tick();
      chk("b2b_ack_end", {31'd0, hs.ack_tgl},  32'd0);
      chk("b2b3_ack_end",{31'd0, hs3.ack_tgl}, 32'd0);
      chk("b2b_err",     {31'd0, err_o},       32'd0);
      chk("b2b3_err",    {31'd0, err3_o},      32'd0);

      // protocol violation: second toggle while holding
      hs.ready_i   = 1'b0;
      hs.data_a    = 32'hDEAD_BEEF;
      hs.req_tgl_a = ~hs.req_tgl_a;
      wait_valid("vio_wait", 10);
      chk("vio_data1", hs.data_o, 32'hDEAD_BEEF);
      tick();
      hs.data_a    = 32'h0BAD_0BAD;
      hs.req_tgl_a = ~hs.req_tgl_a;
      repeat (4) tick();
      chk("vio_err",   {31'd0, err_o},       32'd1);
      chk("vio3_err",  {31'd0, err3_o},      32'd1);
      chk("vio_valid", {31'd0, hs.valid_o},  32'd1);
      chk("vio_data2", hs.data_o,            32'hDEAD_BEEF);
      chk("vio_ack0",  {31'd0, hs.ack_tgl},  32'd0);
      hs.ready_i = 1'b1;
      tick();
      chk("vio_acc_ack", {31'd0, hs.ack_tgl}, 32'd1);
      repeat (5) tick();
      chk("vio_no_recap", {31'd0, hs.valid_o}, 32'd0);
      chk("vio_ack_once", {31'd0, hs.ack_tgl}, 32'd1);
      chk("vio_data3",    hs.data_o,           32'hDEAD_BEEF);
      chk("vio_sticky",   {31'd0, err_o},      32'd1);
      hs.ready_i = 1'b0;

      // level channels
      lvl_a = 2'b01;
      tick();
      chk("lv_e1_lvl",  {30'd0, lvl_o},      32'd0);
      tick();
      chk("lv_e2_lvl",  {30'd0, lvl_o},      32'd1);
      chk("lv_e2_rise", {30'd0, lvl_rise_o}, 32'd1);
      chk("lv_e2_fall", {30'd0, lvl_fall_o}, 32'd0);
      chk("lv3_e2_lvl", {30'd0, lvl3_o},     32'd0);
      tick();
      chk("lv_e3_rise", {30'd0, lvl_rise_o}, 32'd0);
      chk("lv_e3_lvl",  {30'd0, lvl_o},      32'd1);
      chk("lv3_e3_rise",{30'd0, lvl3_rise_o},32'd1);
      lvl_a = 2'b10;
      tick();
      tick();
      chk("lv_sw_lvl",  {30'd0, lvl_o},      32'd2);
      chk("lv_sw_rise", {30'd0, lvl_rise_o}, 32'd2);
      chk("lv_sw_fall", {30'd0, lvl_fall_o}, 32'd1);
      lvl_a = 2'b00;
      tick();
      tick();
      chk("lv_f_lvl",   {30'd0, lvl_o},      32'd0);
      chk("lv_f_fall",  {30'd0, lvl_fall_o}, 32'd2);
      chk("lv_f_rise",  {30'd0, lvl_rise_o}, 32'd0);
      tick();
      chk("lv_f2_fall", {30'd0, lvl_fall_o}, 32'd0);

      // reset while holding
      lvl_a        = 2'b11;
      hs.data_a    = 32'h5555_AAAA;
      hs.req_tgl_a = ~hs.req_tgl_a;
      wait_valid("rh_wait", 10);
      chk("rh_data", hs.data_o, 32'h5555_AAAA);
      tick();
      chk("rh_lvl_pre", {30'd0, lvl_o}, 32'd3);
      rst_n        = 1'b0;
      hs.req_tgl_a = 1'b0;
      lvl_a        = 2'b00;
      tick();
      chk("rh_valid", {31'd0, hs.valid_o}, 32'd0);
      chk("rh_ack",   {31'd0, hs.ack_tgl}, 32'd0);
      chk("rh_err",   {31'd0, err_o},      32'd0);
      chk("rh_lvl",   {30'd0, lvl_o},      32'd0);
      chk("rh_data0", hs.data_o,           32'd0);
      chk("rh3_valid",{31'd0, hs3.valid_o},32'd0);
      rst_n = 1'b1;
      repeat (5) tick();
      chk("rh_quiet", {31'd0, hs.valid_o}, 32'd0);
      chk("rh_ack2",  {31'd0, hs.ack_tgl}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
